// File: rtl/bsg_manycore_link_serializer_pkg.sv
// Shared sizing helpers for the manycore edge-link serializer.
// Packet width mirrors the manycore packet header field layout.
package bsg_manycore_link_serializer_pkg;

  localparam int op_width_gp     = 2;
  localparam int op_ex_width_gp  = 4;
  localparam int reg_id_width_gp = 5;

  // op + op_ex + reg_id + addr + data + src/dst coordinates
  function automatic int packet_width(
    input int a,
    input int d,
    input int x,
    input int y
  );
    return op_width_gp + op_ex_width_gp
         + reg_id_width_gp + a + d
         + 2 * (x + y);
  endfunction

  function automatic int ceil_div(
    input int n,
    input int d
  );
    return (n + d - 1) / d;
  endfunction

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_manycore_link_serializer_if.sv
// Valid/ready bundle between the serializer and its packet buffer.
// Master drives v/data, slave answers with ready.
interface bsg_manycore_link_serializer_if #(
  parameter int width_p = 1
);
  logic               v;
  logic               ready;
  logic [width_p-1:0] data;

  modport master (
    output v,
    output data,
    input  ready
  );

  modport slave (
    input  v,
    input  data,
    output ready
  );
endinterface

// File: rtl/bsg_manycore_link_serializer_fifo.sv
// Two-entry packet buffer, registered storage, no bypass.
// ready is a registered not-full flag so it never sees deq.
module bsg_manycore_link_serializer_fifo #(
  parameter int width_p = 1
)(
  input logic clk,
  input logic rst_n,
  bsg_manycore_link_serializer_if.slave  enq,
  bsg_manycore_link_serializer_if.master deq
);

  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         cnt_r;
  logic [1:0]         cnt_n;
  logic               nfull_r;
  logic               do_enq;
  logic               do_deq;

  assign enq.ready = nfull_r;
  assign deq.v     = (cnt_r != 2'd0);
  assign deq.data  = mem_r[rd_ptr_r];

  assign do_enq = enq.v & nfull_r;
  assign do_deq = deq.v & deq.ready;

  always_comb begin
    cnt_n = cnt_r;
    cnt_n = cnt_r + 2'(do_enq) - 2'(do_deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 2'd0;
      nfull_r  <= 1'b0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_n;
      nfull_r <= (cnt_n != 2'd2);
      if (do_enq) wr_ptr_r <= ~wr_ptr_r;
      if (do_deq) rd_ptr_r <= ~rd_ptr_r;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_r[wr_ptr_r] <= enq.data;
  end

endmodule

// File: rtl/bsg_manycore_link_serializer.sv
// Narrows full manycore packets into channel_width_p slices,
// LSB slice first, with a last-slice marker.
module bsg_manycore_link_serializer
  import bsg_manycore_link_serializer_pkg::*;
#(
  parameter int x_cord_width_p  = 5,
  parameter int y_cord_width_p  = 5,
  parameter int addr_width_p    = 32,
  parameter int data_width_p    = 32,
  parameter int channel_width_p = 16,
  localparam int packet_width_lp = packet_width(
    addr_width_p, data_width_p,
    x_cord_width_p, y_cord_width_p)
)(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [channel_width_p-1:0] data_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int cw_lp = (channel_width_p < 1)
                       ? 1 : channel_width_p;
  localparam int num_slices_lp =
    ceil_div(packet_width_lp, cw_lp);
  localparam int cnt_width_lp = safe_clog2(num_slices_lp);
  localparam logic [cnt_width_lp-1:0] last_idx_lp =
    cnt_width_lp'(num_slices_lp - 1);

  if (channel_width_p < 1) begin : g_bad_width
    $error("channel_width_p must be at least 1");
  end
  if ((1 << cnt_width_lp) < num_slices_lp) begin : g_bad_cnt
    $error("slice counter too narrow");
  end

  bsg_manycore_link_serializer_if #(
    .width_p(packet_width_lp)
  ) enq_if ();
  bsg_manycore_link_serializer_if #(
    .width_p(packet_width_lp)
  ) deq_if ();

  assign enq_if.v    = v_i;
  assign enq_if.data = data_i;
  assign ready_o     = enq_if.ready;

  bsg_manycore_link_serializer_fifo #(
    .width_p(packet_width_lp)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_i),
    .enq   (enq_if),
    .deq   (deq_if)
  );

  // Head packet zero-padded to a whole number of slices
  logic [num_slices_lp-1:0][channel_width_p-1:0] slices;
  logic [cnt_width_lp-1:0] slice_cnt_r;
  logic                    is_last;
  logic                    xfer;

  assign slices =
    (num_slices_lp * channel_width_p)'(deq_if.data);

  assign is_last = (slice_cnt_r == last_idx_lp);
  assign v_o     = deq_if.v;
  assign data_o  = slices[slice_cnt_r];
  assign last_o  = v_o & is_last;
  assign xfer    = v_o & ready_i;

  assign deq_if.ready = xfer & is_last;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      slice_cnt_r <= '0;
    end else if (xfer) begin
      slice_cnt_r <= is_last
        ? '0 : slice_cnt_r + cnt_width_lp'(1);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_link_serializer.sv
// Bench for the link serializer: narrow and wide channels
// checked against a queue-of-slices reference model.
module tb_bsg_manycore_link_serializer;
  import bsg_manycore_link_serializer_pkg::*;

  localparam int PW = packet_width(32, 32, 5, 5);
  localparam int CW = 16;
  localparam int NS = (PW + CW - 1) / CW;
  localparam int WW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;
  logic last_o;

  bsg_manycore_link_serializer_if #(.width_p(PW)) in_bus ();
  bsg_manycore_link_serializer_if #(.width_p(CW)) out_bus ();

  bsg_manycore_link_serializer #(
    .channel_width_p(CW)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (in_bus.v),
    .data_i  (in_bus.data),
    .ready_o (in_bus.ready),
    .v_o     (out_bus.v),
    .data_o  (out_bus.data),
    .last_o  (last_o),
    .ready_i (out_bus.ready)
  );

  logic          w_v_i;
  logic [PW-1:0] w_data_i;
  logic          w_ready_o;
  logic          w_v_o;
  logic [WW-1:0] w_data_o;
  logic          w_last_o;
  logic          w_ready_i;

  bsg_manycore_link_serializer #(
    .channel_width_p(WW)
  ) dut_w (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (w_v_i),
    .data_i  (w_data_i),
    .ready_o (w_ready_o),
    .v_o     (w_v_o),
    .data_o  (w_data_o),
    .last_o  (w_last_o),
    .ready_i (w_ready_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [CW-1:0] d;
    logic          l;
  } xfer_t;

  logic [CW-1:0] sq_d[$];
  logic          sq_l[$];
  xfer_t         log_q[$];
  logic [PW-1:0] wq[$];
  int occ     = 0;
  int rel_cnt = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int w_acc   = 0;
  int w_xfer  = 0;

  function automatic logic [CW-1:0] slice_of(
    input logic [PW-1:0] p,
    input int            k
  );
    logic [NS*CW-1:0] z;
    z = (NS * CW)'(p);
    return CW'(z >> (k * CW));
  endfunction

  task automatic push_pkt(input logic [PW-1:0] p);
    for (int k = 0; k < NS; k++) begin
      sq_d.push_back(slice_of(p, k));
      sq_l.push_back(k == NS - 1);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset_i) begin
      check("rst_v", 128'(out_bus.v), 128'(0));
      check("rst_rdy", 128'(in_bus.ready), 128'(0));
      sq_d.delete();
      sq_l.delete();
      occ     = 0;
      rel_cnt = 0;
    end else begin
      check("ready", 128'(in_bus.ready),
            128'(rel_cnt > 0 && occ < 2));
      check("valid", 128'(out_bus.v), 128'(occ > 0));
      if (out_bus.v) begin
        if (sq_d.size() == 0)
          check("extra_slice", 128'(1), 128'(0));
        else begin
          check("slice", 128'(out_bus.data), 128'(sq_d[0]));
          check("last", 128'(last_o), 128'(sq_l[0]));
        end
      end
      if (out_bus.v && out_bus.ready && sq_d.size() > 0) begin
        log_q.push_back('{cyc, out_bus.data, last_o});
        if (sq_l[0]) occ--;
        void'(sq_d.pop_front());
        void'(sq_l.pop_front());
      end
      if (in_bus.v && in_bus.ready) begin
        push_pkt(in_bus.data);
        occ++;
        n_acc++;
      end
      rel_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!reset_i) begin
      wq.delete();
    end else begin
      if (w_v_o) begin
        check("w_last", 128'(w_last_o), 128'(1));
        if (wq.size() == 0)
          check("w_extra", 128'(1), 128'(0));
        else
          check("w_data", 128'(w_data_o), 128'(wq[0]));
      end
      if (w_v_o && w_ready_i && wq.size() > 0) begin
        void'(wq.pop_front());
        w_xfer++;
      end
      if (w_v_i && w_ready_o) begin
        wq.push_back(w_data_i);
        w_acc++;
      end
    end
  end

  function automatic logic [PW-1:0] rand_pkt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return PW'(r);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves v high with the packet on the bus once accepted
  task automatic send(input logic [PW-1:0] p);
    bit ok;
    ok = 1'b0;
    in_bus.v    = 1'b1;
    in_bus.data = p;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_bus.ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) check("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (occ == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) check("drain_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_log(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (log_q.size() >= n) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) check("log_timeout", 128'(0), 128'(1));
  endtask

  logic [PW-1:0] pk;
  logic [PW-1:0] bp[3];
  logic [CW-1:0] held;
  int a0;
  int wa0;
  int wx0;

  initial begin
    reset_i       = 1'b0;
    in_bus.v      = 1'b1;
    in_bus.data   = rand_pkt();
    out_bus.ready = 1'b1;
    w_v_i         = 1'b0;
    w_data_i      = '0;
    w_ready_i     = 1'b1;

    tick(5);
    in_bus.v = 1'b0;
    reset_i  = 1'b1;
    @(negedge clk);
    check("rdy_pre", 128'(in_bus.ready), 128'(0));
    @(posedge clk);
    #1;
    check("rdy_up", 128'(in_bus.ready), 128'(1));
    tick(2);
    check("no_acc", 128'(n_acc), 128'(0));
    check("v_idle", 128'(out_bus.v), 128'(0));

    log_q.delete();
    pk        = '0;
    pk[31:0]  = 32'hCAFE_BEEF;
    send(pk);
    in_bus.v = 1'b0;
    check("latency", 128'(out_bus.v), 128'(1));
    wait_drain();
    check("sp_n", 128'(log_q.size()), 128'(NS));
    if (log_q.size() == NS) begin
      check("sp_s0", 128'(log_q[0].d), 128'(16'hBEEF));
      check("sp_s1", 128'(log_q[1].d), 128'(16'hCAFE));
      for (int k = 2; k < NS; k++)
        check("sp_zero", 128'(log_q[k].d), 128'(0));
      for (int k = 0; k < NS; k++)
        check("sp_last", 128'(log_q[k].l),
              128'(k == NS - 1));
      check("sp_contig",
            128'(log_q[NS-1].cyc - log_q[0].cyc),
            128'(NS - 1));
    end

    log_q.delete();
    out_bus.ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 3; i++) bp[i] = rand_pkt();
    fork
      begin
        send(bp[0]);
        send(bp[1]);
        send(bp[2]);
        in_bus.v = 1'b0;
      end
    join_none
    tick(6);
    check("bp_acc2", 128'(n_acc - a0), 128'(2));
    check("bp_rdy", 128'(in_bus.ready), 128'(0));
    out_bus.ready = 1'b1;
    wait_drain();
    wait fork;
    check("bp_acc3", 128'(n_acc - a0), 128'(3));
    check("bp_n", 128'(log_q.size()), 128'(3 * NS));
    if (log_q.size() == 3 * NS)
      check("bp_contig",
            128'(log_q[3*NS-1].cyc - log_q[0].cyc),
            128'(3 * NS - 1));

    log_q.delete();
    pk = rand_pkt();
    send(pk);
    in_bus.v = 1'b0;
    wait_log(2);
    out_bus.ready = 1'b0;
    held = out_bus.data;
    check("stall_s2", 128'(held), 128'(slice_of(pk, 2)));
    repeat (4) begin
      tick();
      check("stall_data", 128'(out_bus.data), 128'(held));
      check("stall_cnt", 128'(dut.slice_cnt_r), 128'(2));
    end
    out_bus.ready = 1'b1;
    wait_drain();
    if (log_q.size() == NS) begin
      check("stall_next", 128'(log_q[2].d),
            128'(slice_of(pk, 2)));
      check("stall_gap",
            128'(log_q[2].cyc - log_q[1].cyc), 128'(5));
    end else
      check("stall_n", 128'(log_q.size()), 128'(NS));

    log_q.delete();
    send(rand_pkt());
    send(rand_pkt());
    in_bus.v = 1'b0;
    wait_log(2);
    reset_i = 1'b0;
    #1;
    check("rst_v_comb", 128'(out_bus.v), 128'(0));
    check("rst_last", 128'(last_o), 128'(0));
    tick(2);
    reset_i = 1'b1;
    tick(3);
    check("rst_no_tail", 128'(out_bus.v), 128'(0));
    log_q.delete();
    pk = rand_pkt();
    send(pk);
    in_bus.v = 1'b0;
    wait_drain();
    check("rst_new_n", 128'(log_q.size()), 128'(NS));
    if (log_q.size() > 0)
      check("rst_new_s0", 128'(log_q[0].d),
            128'(slice_of(pk, 0)));

    for (int i = 0; i < 600; i++) begin
      in_bus.v      = ($urandom_range(0, 2) != 0);
      in_bus.data   = rand_pkt();
      out_bus.ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_bus.v      = 1'b0;
    out_bus.ready = 1'b1;
    wait_drain();

    wa0 = w_acc;
    wx0 = w_xfer;
    for (int i = 0; i < 20; i++) begin
      w_v_i    = 1'b1;
      w_data_i = rand_pkt();
      tick();
    end
    w_v_i = 1'b0;
    tick(3);
    check("w_acc", 128'(w_acc - wa0), 128'(20));
    check("w_xfer", 128'(w_xfer - wx0), 128'(20));
    for (int i = 0; i < 200; i++) begin
      w_v_i     = ($urandom_range(0, 1) != 0);
      w_data_i  = rand_pkt();
      w_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    w_v_i     = 1'b0;
    w_ready_i = 1'b1;
    tick(5);
    check("w_drain", 128'(w_acc - w_xfer), 128'(0));

    check("end_empty", 128'(sq_d.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
